// File: rtl/tcp_vlg_pkg.sv
// Shared types and constants for the TCP option parser.
// TCP_VLG_OPT_TIMESTAMP_EN enables timestamp capture in the parser.
package tcp_vlg_pkg;

  localparam int TCP_VLG_SACK_MAX = 4;

  localparam logic [7:0] TCP_OPT_END       = 8'd0;
  localparam logic [7:0] TCP_OPT_NOP       = 8'd1;
  localparam logic [7:0] TCP_OPT_MSS       = 8'd2;
  localparam logic [7:0] TCP_OPT_WND       = 8'd3;
  localparam logic [7:0] TCP_OPT_SACK_PERM = 8'd4;
  localparam logic [7:0] TCP_OPT_SACK      = 8'd5;
  localparam logic [7:0] TCP_OPT_TIMESTAMP = 8'd8;

  localparam logic [7:0] TCP_OPT_LEN_MSS       = 8'd4;
  localparam logic [7:0] TCP_OPT_LEN_WND       = 8'd3;
  localparam logic [7:0] TCP_OPT_LEN_SACK_PERM = 8'd2;
  localparam logic [7:0] TCP_OPT_LEN_TIMESTAMP = 8'd10;

  localparam logic [3:0] TCP_MAX_WIN_SCALE = 4'd14;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KIND = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    PAD  = 3'd4,
    DONE = 3'd5
  } tcp_vlg_state_e;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } tcp_vlg_sack_blk_t;

  // Block array is sized for the maximum; the parser fills only SACK_BLOCKS entries.
  typedef struct packed {
    logic                                    mss_pres;
    logic [15:0]                             mss;
    logic                                    wnd_pres;
    logic [3:0]                              wnd;
    logic                                    sack_perm;
    logic [TCP_VLG_SACK_MAX-1:0]             block_pres;
    tcp_vlg_sack_blk_t [TCP_VLG_SACK_MAX-1:0] blocks;
    logic                                    timestamp_pres;
    logic [31:0]                             snd;
    logic [31:0]                             rec;
  } tcp_vlg_opt_t;

  // A SACK option carries at least one 8-byte block after kind and length.
  function automatic logic sack_len_ok(input logic [7:0] len);
    return (len >= 8'd10) && (len[2:0] == 3'd2);
  endfunction

endpackage

// File: rtl/tcp_vlg_opt_parse.sv
// Byte-serial TCP option parser producing a registered option record.
// Timestamp capture is compiled in only with TCP_VLG_OPT_TIMESTAMP_EN.
//
// state | meaning
// IDLE  | waiting for sof_in; opt_out holds the last result
// KIND  | next accepted byte is an option kind
// LEN   | next accepted byte is the option length
// DATA  | consuming option payload bytes
// PAD   | discarding bytes until the region ends
// DONE  | val_out asserted for one cycle
module tcp_vlg_opt_parse
  import tcp_vlg_pkg::*;
#(
  parameter int SACK_BLOCKS   = 4,
  parameter int MAX_OPT_BYTES = 40
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        dat_in,
  input  logic                              val_in,
  input  logic                              sof_in,
  input  logic [5:0]                        opt_len_in,
  output logic [$bits(tcp_vlg_opt_t)-1:0]   opt_out,
  output logic                              val_out,
  output logic                              err_out
);

  localparam logic [6:0] MAX_BYTES = 7'(MAX_OPT_BYTES);
  localparam logic [3:0] NUM_BLKS  = 4'(SACK_BLOCKS);

  tcp_vlg_state_e state;
  tcp_vlg_opt_t   opt_q;
  logic [5:0]     cnt;
  logic [7:0]     kind;
  logic [5:0]     dlen;
  logic [5:0]     idx;
  logic           err_flag;

  logic           start;
  logic           too_big;
  logic [5:0]     rem;
  logic [5:0]     rem_dec;
  logic           last;
  logic           len_bad;
  logic [1:0]     blk;
  logic           blk_kept;

  assign opt_out = opt_q;

  always_comb begin
    start    = val_in && sof_in;
    too_big  = {1'b0, opt_len_in} > MAX_BYTES;
    rem      = start ? opt_len_in : cnt;
    rem_dec  = rem - 6'd1;
    last     = (rem_dec == 6'd0);
    blk      = idx[4:3];
    blk_kept = {2'b00, blk} < NUM_BLKS;
  end

  // Length byte validity; cnt still includes the length byte itself here.
  always_comb begin
    len_bad = 1'b0;
    if (dat_in < 8'd2) begin
      len_bad = 1'b1;
    end else if (dat_in > ({2'b00, cnt} + 8'd1)) begin
      len_bad = 1'b1;
    end else begin
      case (kind)
        TCP_OPT_MSS:       len_bad = (dat_in != TCP_OPT_LEN_MSS);
        TCP_OPT_WND:       len_bad = (dat_in != TCP_OPT_LEN_WND);
        TCP_OPT_SACK_PERM: len_bad = (dat_in != TCP_OPT_LEN_SACK_PERM);
        TCP_OPT_SACK:      len_bad = !sack_len_ok(dat_in);
`ifdef TCP_VLG_OPT_TIMESTAMP_EN
        TCP_OPT_TIMESTAMP: len_bad = (dat_in != TCP_OPT_LEN_TIMESTAMP);
`endif
        default:           len_bad = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      opt_q    <= '0;
      cnt      <= '0;
      kind     <= '0;
      dlen     <= '0;
      idx      <= '0;
      err_flag <= 1'b0;
      val_out  <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      val_out <= 1'b0;
      err_out <= 1'b0;
      if (start && (opt_len_in == 6'd0)) begin
        opt_q    <= '0;
        err_flag <= 1'b0;
        cnt      <= '0;
        state    <= DONE;
        val_out  <= 1'b1;
      end else if (start && too_big) begin
        opt_q    <= '0;
        err_flag <= 1'b1;
        err_out  <= 1'b1;
        cnt      <= rem_dec;
        state    <= PAD;
      end else if (start || (val_in && (state == KIND))) begin
        // The sof byte is always interpreted as a kind byte.
        if (start) begin
          opt_q    <= '0;
          err_flag <= 1'b0;
        end
        cnt  <= rem_dec;
        kind <= dat_in;
        if (dat_in == TCP_OPT_END) begin
          state   <= last ? DONE : PAD;
          val_out <= last;
        end else if (dat_in == TCP_OPT_NOP) begin
          state   <= last ? DONE : KIND;
          val_out <= last;
        end else if (last) begin
          opt_q    <= '0;
          err_flag <= 1'b1;
          err_out  <= 1'b1;
          state    <= IDLE;
        end else begin
          state <= LEN;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (val_in) begin
        case (state)
          LEN: begin
            cnt <= rem_dec;
            if (len_bad) begin
              opt_q    <= '0;
              err_flag <= 1'b1;
              err_out  <= 1'b1;
              state    <= last ? IDLE : PAD;
            end else begin
              idx  <= '0;
              dlen <= dat_in[5:0] - 6'd2;
              if (kind == TCP_OPT_SACK_PERM) opt_q.sack_perm <= 1'b1;
              if (kind == TCP_OPT_SACK) begin
                opt_q.blocks     <= '0;
                opt_q.block_pres <= '0;
              end
              if (dat_in == 8'd2) begin
                state   <= last ? DONE : KIND;
                val_out <= last;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            cnt <= rem_dec;
            idx <= idx + 6'd1;
            case (kind)
              TCP_OPT_MSS: begin
                if (idx == 6'd0) begin
                  opt_q.mss[15:8] <= dat_in;
                end else begin
                  opt_q.mss[7:0] <= dat_in;
                  opt_q.mss_pres <= 1'b1;
                end
              end
              TCP_OPT_WND: begin
                opt_q.wnd      <= (dat_in > {4'd0, TCP_MAX_WIN_SCALE}) ? TCP_MAX_WIN_SCALE
                                                                      : dat_in[3:0];
                opt_q.wnd_pres <= 1'b1;
              end
              TCP_OPT_SACK: begin
                // Blocks beyond SACK_BLOCKS are consumed but not stored.
                if (blk_kept) begin
                  if (!idx[2]) begin
                    opt_q.blocks[blk].left <= {opt_q.blocks[blk].left[23:0], dat_in};
                  end else begin
                    opt_q.blocks[blk].right <= {opt_q.blocks[blk].right[23:0], dat_in};
                  end
                  if (idx[2:0] == 3'd7) opt_q.block_pres[blk] <= 1'b1;
                end
              end
`ifdef TCP_VLG_OPT_TIMESTAMP_EN
              TCP_OPT_TIMESTAMP: begin
                if (!idx[2]) begin
                  opt_q.snd <= {opt_q.snd[23:0], dat_in};
                end else begin
                  opt_q.rec <= {opt_q.rec[23:0], dat_in};
                end
                if (idx[2:0] == 3'd7) opt_q.timestamp_pres <= 1'b1;
              end
`endif
              default: ;
            endcase
            if (idx == (dlen - 6'd1)) begin
              state   <= last ? DONE : KIND;
              val_out <= last;
            end
          end
          PAD: begin
            cnt <= rem_dec;
            if (last) begin
              state   <= err_flag ? IDLE : DONE;
              val_out <= !err_flag;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcp_vlg_opt_parse.sv
// Scoreboard bench for tcp_vlg_opt_parse; the driver queues expected pulses,
// the monitor pops and compares whenever val_out or err_out is seen.
module tb_tcp_vlg_opt_parse;
  import tcp_vlg_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [7:0]                      dat_in;
  logic                            val_in;
  logic                            sof_in;
  logic [5:0]                      opt_len_in;
  logic [$bits(tcp_vlg_opt_t)-1:0] opt_out;
  logic                            val_out;
  logic                            err_out;

  always #5 clk = ~clk;

  tcp_vlg_opt_parse #(
    .SACK_BLOCKS  (2),
    .MAX_OPT_BYTES(40)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dat_in    (dat_in),
    .val_in    (val_in),
    .sof_in    (sof_in),
    .opt_len_in(opt_len_in),
    .opt_out   (opt_out),
    .val_out   (val_out),
    .err_out   (err_out)
  );

  typedef struct {
    string        name;
    bit           is_err;
    tcp_vlg_opt_t opt;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [7:0]   bq[$];
  tcp_vlg_opt_t ex;
  tcp_vlg_opt_t none;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (val_out || err_out)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected pulse: val_out=%0b err_out=%0b cycle %0d, none expected",
                 val_out, err_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " pulse"}, 512'({val_out, err_out}),
              512'({!mon_e.is_err, mon_e.is_err}));
        check({mon_e.name, " latency"}, 512'(cyc), 512'(mon_e.cyc));
        if (!mon_e.is_err) check({mon_e.name, " opt_out"}, 512'(opt_out), 512'(mon_e.opt));
      end
    end
  end

  task automatic load(input int n, input logic [255:0] v);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // pulse_at: index of the byte after which a pulse is due (-1: none).
  task automatic send(input logic [5:0] len, input bit with_sof, input int pulse_at,
                      input bit is_err, input tcp_vlg_opt_t opt, input string name,
                      input int stall_at);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == stall_at) begin
        @(negedge clk);
        val_in = 1'b0;
        sof_in = 1'b0;
      end
      @(negedge clk);
      dat_in     = bq[i];
      val_in     = 1'b1;
      sof_in     = with_sof && (i == 0);
      opt_len_in = len;
      if (i == pulse_at) begin
        exp_t e;
        e.name   = name;
        e.is_err = is_err;
        e.opt    = opt;
        e.cyc    = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    val_in = 1'b0;
    sof_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    none       = '0;
    rst        = 1'b1;
    val_in     = 1'b0;
    sof_in     = 1'b0;
    dat_in     = 8'h00;
    opt_len_in = 6'd0;
    repeat (3) @(negedge clk);
    check("reset opt_out", 512'(opt_out), 512'(0));
    check("reset val_out", 512'(val_out), 512'(0));
    check("reset err_out", 512'(err_out), 512'(0));
    rst = 1'b0;
    idle(2);

    // MSS
    ex = '0; ex.mss = 16'h05B4; ex.mss_pres = 1'b1;
    load(4, 256'h020405B4);
    send(6'd4, 1'b1, 3, 1'b0, ex, "mss", -1);
    idle(3);

    // NOP/WND/SACK_PERM/END padding, with a stall mid-region
    ex = '0; ex.wnd = 4'd7; ex.wnd_pres = 1'b1; ex.sack_perm = 1'b1;
    load(12, 256'h01030307_04020101_00000000);
    send(6'd12, 1'b1, 11, 1'b0, ex, "wnd_sackperm", 5);
    idle(3);

    // Three SACK blocks with two stored
    ex = '0;
    ex.blocks[0].left  = 32'h00000011; ex.blocks[0].right = 32'h00000022;
    ex.blocks[1].left  = 32'h33333333; ex.blocks[1].right = 32'h44444444;
    ex.block_pres = 4'b0011;
    load(28, 256'h051A_00000011_00000022_33333333_44444444_55555555_66666666_0101);
    send(6'd28, 1'b1, 27, 1'b0, ex, "sack3", -1);
    idle(3);

    // len < 2
    load(4, 256'h02010000);
    send(6'd4, 1'b1, 1, 1'b1, none, "len_lt2", -1);
    idle(3);

    // Timestamp
    ex = '0;
`ifdef TCP_VLG_OPT_TIMESTAMP_EN
    ex.snd = 32'd1; ex.rec = 32'd2; ex.timestamp_pres = 1'b1;
`endif
    load(12, 256'h080A_00000001_00000002_0101);
    send(6'd12, 1'b1, 11, 1'b0, ex, "timestamp", -1);
    idle(3);

    // Restart mid-SACK, then MSS
    load(4, 256'h050A0000);
    send(6'd12, 1'b1, -1, 1'b0, none, "abandoned", -1);
    ex = '0; ex.mss = 16'h05DC; ex.mss_pres = 1'b1;
    load(4, 256'h020405DC);
    send(6'd4, 1'b1, 3, 1'b0, ex, "restart_mss", -1);
    idle(3);

    // Reset mid-region
    load(3, 256'h020405);
    send(6'd4, 1'b1, -1, 1'b0, none, "partial", -1);
    @(negedge clk);
    val_in = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("rst mid opt_out", 512'(opt_out), 512'(0));
    check("rst mid val_out", 512'(val_out), 512'(0));
    rst = 1'b0;
    load(4, 256'h02040101);
    send(6'd4, 1'b0, -1, 1'b0, none, "no_sof", -1);
    idle(3);

    // Window scale clamp, then opt_out must hold
    ex = '0; ex.wnd = 4'd14; ex.wnd_pres = 1'b1;
    load(4, 256'h03032001);
    send(6'd4, 1'b1, 3, 1'b0, ex, "wnd_clamp", -1);
    idle(5);
    check("hold opt_out", 512'(opt_out), 512'(ex));

    // MSS with wrong fixed length
    load(4, 256'h02030000);
    send(6'd4, 1'b1, 1, 1'b1, none, "mss_badlen", -1);
    idle(3);

    // Length larger than what remains
    load(4, 256'h02080000);
    send(6'd4, 1'b1, 1, 1'b1, none, "len_overrun", -1);
    idle(3);

    // SACK length not 2+8n
    load(8, 256'h05060000_00000000);
    send(6'd8, 1'b1, 1, 1'b1, none, "sack_badlen", -1);
    idle(3);

    // Region longer than MAX_OPT_BYTES
    load(41, 256'h0);
    send(6'd41, 1'b1, 0, 1'b1, none, "too_long", -1);
    idle(3);

    // Empty region
    load(1, 256'h0);
    send(6'd0, 1'b1, 0, 1'b0, none, "empty", -1);
    idle(3);

    // Unknown kind skipped, repeated MSS last wins
    ex = '0; ex.mss = 16'h0102; ex.mss_pres = 1'b1;
    load(12, 256'h02041111_1E04AABB_02040102);
    send(6'd12, 1'b1, 11, 1'b0, ex, "unknown_repeat", -1);
    idle(3);

    // END followed by nonzero padding
    ex = '0; ex.mss = 16'h05B4; ex.mss_pres = 1'b1;
    load(8, 256'h020405B4_00A5C3FF);
    send(6'd8, 1'b1, 7, 1'b0, ex, "end_pad", -1);
    idle(3);

    // Kind byte as the last byte of the region
    load(4, 256'h01010102);
    send(6'd4, 1'b1, 3, 1'b1, none, "kind_at_end", -1);
    idle(6);

    check("scoreboard drained", 512'(sb.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
